// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for a 5-stage in-order pipeline. Decides, every
// cycle, which pipeline registers load and which get a bubble, based on
// load-use and branch-operand dependencies, instruction-fetch misses, data
// memory misses and the halt instruction.
//
// A small registered FSM tracks the global pipeline mode:
//   RUN    (0) : normal operation, stage controls follow the hazard rules
//   DWAIT  (1) : waiting for a data-memory access to complete, full freeze
//   HALTED (2) : pipeline permanently stopped until reset
// All stage controls are combinational in the FSM state and the inputs.
//
// Optional feature (macro HAZARD_PERF_EN): two wrapping performance counters,
// stall_cnt (cycles with the PC held, outside HALTED) and flush_cnt (IF/ID
// flushes caused by a taken branch). When the macro is undefined, the counter
// registers are absent and both counter outputs are tied to zero.
//
// Ports
//   CLK, RST                 clock, synchronous active-high reset
//   ihit, dhit               instruction fetch returned / data access done
//   id_rs, id_rt, id_uses_rt ID-stage source registers, rt-used flag
//   id_is_branch             ID holds a branch/jr resolved in ID
//   ex_rd, ex_memRead,
//   ex_regWr                 EX-stage destination, load flag, write flag
//   mem_rd, mem_memRead,
//   mem_dmemReq              MEM-stage destination, load flag, memory access
//   branch_taken             ID branch resolved taken
//   halt                     halt instruction in MEM
//   pc_en .. memwb_en        pipeline register load enables
//   ifid_flush, idex_flush   bubble insertion into IF/ID, ID/EX
//   halted                   pipeline permanently stopped
//   state                    FSM state (debug)
//   stall_cnt, flush_cnt     performance counters
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             id_is_branch,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memRead,
  input  logic             ex_regWr,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_memRead,
  input  logic             mem_dmemReq,
  input  logic             branch_taken,
  input  logic             halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t cur_state, nxt_state;

  logic ex_match, mem_match;
  logic load_use, br_dep, hazard;
  logic dmiss;
  logic run_rules;

  // Register 0 is hard-wired to zero, so a write to it never creates a
  // dependency. rt only counts when the ID instruction actually reads it.
  assign ex_match  = (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
  assign mem_match = (mem_rd != '0) &&
                     ((mem_rd == id_rs) || (id_uses_rt && (mem_rd == id_rt)));

  assign load_use = ex_memRead && ex_match;
  // Branches resolve in ID, so they also wait on an ALU result still in EX
  // and on a load still in MEM. A load followed by a dependent branch is
  // caught by load_use in the first cycle and by the MEM term in the second.
  assign br_dep   = id_is_branch &&
                    ((ex_regWr && ex_match) || (mem_memRead && mem_match));
  assign hazard   = load_use || br_dep;
  assign dmiss    = mem_dmemReq && !dhit;

  always_ff @(posedge CLK) begin
    if (RST) cur_state <= RUN;
    else     cur_state <= nxt_state;
  end

  always_comb begin
    nxt_state  = cur_state;
    run_rules  = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;

    case (cur_state)
      RUN: begin
        if (halt) begin
          nxt_state = HALTED;
          run_rules = 1'b1;
        end else if (dmiss) begin
          // The cycle that detects the miss already freezes everything.
          nxt_state = DWAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      DWAIT: begin
        // The completing cycle behaves like a normal RUN cycle.
        if (dhit) begin
          nxt_state = RUN;
          run_rules = 1'b1;
        end
      end
      HALTED: nxt_state = HALTED;
      default: nxt_state = RUN;
    endcase

    if (run_rules) begin
      if (hazard) begin
        // Hold PC and IF/ID, bubble into EX; branch_taken is not trusted
        // because the branch operands are not yet available.
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end else if (branch_taken) begin
        // Redirect fetch and squash the wrong-path instruction, even if
        // the fetch of that instruction has not returned.
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
      end else if (!ihit) begin
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
        ifid_flush = 1'b1;
      end else begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        memwb_en   = 1'b1;
      end
    end

    if (RST) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
    end
  end

  assign state  = cur_state;
  assign halted = (cur_state == HALTED);

`ifdef HAZARD_PERF_EN
  logic             stall_inc, flush_inc;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_inc = !RST && !pc_en && (cur_state != HALTED);
  assign flush_inc = !RST && run_rules && !hazard && branch_taken;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_inc) stall_q <= stall_q + 1'b1;
      if (flush_inc) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit: a table of single-cycle RUN-state vectors
// followed by hand-written multi-cycle sequences (load/branch stall, data
// miss wait, halt, reset out of DWAIT, branch flush counting). Inputs change
// 1 ns after the rising edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int REG_W = 5;
  localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Stage controls packed as {pc,ifid,idex,exmem,memwb,ifid_flush,idex_flush}
  localparam logic [6:0] EN_ALL  = 7'b1111100;
  localparam logic [6:0] EN_NONE = 7'b0000000;
  localparam logic [6:0] EN_STL  = 7'b0011101;
  localparam logic [6:0] EN_IMIS = 7'b0111110;
  localparam logic [6:0] EN_BR   = 7'b1111110;

  logic             CLK = 1'b0;
  logic             RST;
  logic             ihit, dhit;
  logic [REG_W-1:0] id_rs, id_rt;
  logic             id_uses_rt, id_is_branch;
  logic [REG_W-1:0] ex_rd;
  logic             ex_memRead, ex_regWr;
  logic [REG_W-1:0] mem_rd;
  logic             mem_memRead, mem_dmemReq;
  logic             branch_taken, halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, halted;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_unit #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .ex_rd(ex_rd), .ex_memRead(ex_memRead),
    .ex_regWr(ex_regWr), .mem_rd(mem_rd), .mem_memRead(mem_memRead),
    .mem_dmemReq(mem_dmemReq), .branch_taken(branch_taken), .halt(halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halted(halted), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Clock and timeout
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  typedef struct {
    string            name;
    logic             ihit;
    logic [REG_W-1:0] id_rs, id_rt;
    logic             id_uses_rt, id_is_branch;
    logic [REG_W-1:0] ex_rd;
    logic             ex_memRead, ex_regWr;
    logic [REG_W-1:0] mem_rd;
    logic             mem_memRead, mem_dmemReq, branch_taken;
    logic [6:0]       exp_en;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [6:0] en_vec();
    return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};
  endfunction

  // Driver tasks
  task automatic clr();
    ihit = 1'b1; dhit = 1'b1;
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    ex_rd = '0; ex_memRead = 1'b0; ex_regWr = 1'b0;
    mem_rd = '0; mem_memRead = 1'b0; mem_dmemReq = 1'b0;
    branch_taken = 1'b0; halt = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ihit = v.ihit; dhit = 1'b1;
    id_rs = v.id_rs; id_rt = v.id_rt;
    id_uses_rt = v.id_uses_rt; id_is_branch = v.id_is_branch;
    ex_rd = v.ex_rd; ex_memRead = v.ex_memRead; ex_regWr = v.ex_regWr;
    mem_rd = v.mem_rd; mem_memRead = v.mem_memRead;
    mem_dmemReq = v.mem_dmemReq; branch_taken = v.branch_taken; halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic sample();
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clr();
    tick();
    RST = 1'b0;
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string n, input logic ih, input logic [4:0] rs,
                     input logic [4:0] rt, input logic urt, input logic br,
                     input logic [4:0] erd, input logic emr, input logic ewr,
                     input logic [4:0] mrd, input logic mmr, input logic mdr,
                     input logic bt, input logic [6:0] e);
    vec_t v;
    v.name = n; v.ihit = ih; v.id_rs = rs; v.id_rt = rt; v.id_uses_rt = urt;
    v.id_is_branch = br; v.ex_rd = erd; v.ex_memRead = emr; v.ex_regWr = ewr;
    v.mem_rd = mrd; v.mem_memRead = mmr; v.mem_dmemReq = mdr;
    v.branch_taken = bt; v.exp_en = e;
    vecs.push_back(v);
  endtask

  initial begin
    //   name            ih rs rt urt br erd emr ewr mrd mmr mdr bt  expected
    add("idle",          1, 1, 2, 1,  0, 3,  0,  1,  4,  0,  0,  0, EN_ALL);
    add("imiss",         0, 1, 2, 1,  0, 3,  0,  1,  4,  0,  0,  0, EN_IMIS);
    add("br_imiss",      0, 1, 2, 1,  1, 3,  0,  1,  4,  0,  0,  1, EN_BR);
    add("br_taken",      1, 1, 2, 1,  1, 3,  0,  1,  4,  0,  0,  1, EN_BR);
    add("lu_rs",         1, 8, 2, 0,  0, 8,  1,  1,  0,  0,  0,  0, EN_STL);
    add("lu_rt_unused",  1, 1, 8, 0,  0, 8,  1,  1,  0,  0,  0,  0, EN_ALL);
    add("lu_rt_used",    1, 1, 8, 1,  0, 8,  1,  1,  0,  0,  0,  0, EN_STL);
    add("lu_r0",         1, 0, 0, 1,  0, 0,  1,  1,  0,  0,  0,  0, EN_ALL);
    add("lu_over_imiss", 0, 8, 2, 0,  0, 8,  1,  1,  0,  0,  0,  0, EN_STL);
    add("lu_over_br",    1, 8, 2, 0,  1, 8,  1,  1,  0,  0,  0,  1, EN_STL);
    add("brdep_ex",      1, 3, 2, 0,  1, 3,  0,  1,  0,  0,  0,  1, EN_STL);
    add("ex_wr_nobr",    1, 3, 2, 0,  0, 3,  0,  1,  0,  0,  0,  0, EN_ALL);
    add("ex_nowr_br",    1, 3, 2, 0,  1, 3,  0,  0,  0,  0,  0,  1, EN_BR);
    add("brdep_mem_rt",  1, 1, 4, 1,  1, 0,  0,  0,  4,  1,  0,  1, EN_STL);
    add("mem_noload_br", 1, 1, 4, 1,  1, 0,  0,  0,  4,  0,  0,  1, EN_BR);
    add("brdep_r0",      1, 0, 0, 1,  1, 0,  0,  1,  0,  1,  0,  1, EN_BR);
    add("dmem_hit",      1, 1, 2, 1,  0, 3,  0,  1,  4,  0,  1,  0, EN_ALL);
  end

  initial begin
    RST = 1'b1;
    clr();
    #1;

    // Reset: controls held low while RST, then RUN/zeroed counters
    sample();
    check("rst_enables", {25'd0, en_vec()}, {25'd0, EN_NONE});
    tick();
    RST = 1'b0;
    check("rst_state", {30'd0, state}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_stall_cnt", stall_cnt, 32'd0);
    check("rst_flush_cnt", flush_cnt, 32'd0);

    // Table of single-cycle RUN vectors
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i]);
      sample();
      check(vecs[i].name, {25'd0, en_vec()}, {25'd0, vecs[i].exp_en});
      tick();
      check({vecs[i].name, "_state"}, {30'd0, state}, 32'd0);
    end

    // Load-use: one stall cycle then normal flow
    do_reset();
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8;
    sample();
    check("lu1_stall", {25'd0, en_vec()}, {25'd0, EN_STL});
    tick();
    clr();
    sample();
    check("lu1_resume", {25'd0, en_vec()}, {25'd0, EN_ALL});
    tick();

    // lw $9 ; beq $9,$0 : two stalls, then taken branch resolves
    clr();
    ex_memRead = 1'b1; ex_regWr = 1'b1; ex_rd = 5'd9;
    id_is_branch = 1'b1; id_rs = 5'd9; id_rt = 5'd0; id_uses_rt = 1'b1;
    branch_taken = 1'b1;
    sample();
    check("lwbr_stall1", {25'd0, en_vec()}, {25'd0, EN_STL});
    tick();
    ex_memRead = 1'b0; ex_regWr = 1'b0; ex_rd = '0;
    mem_memRead = 1'b1; mem_rd = 5'd9; mem_dmemReq = 1'b1; dhit = 1'b1;
    sample();
    check("lwbr_stall2", {25'd0, en_vec()}, {25'd0, EN_STL});
    tick();
    mem_memRead = 1'b0; mem_rd = '0; mem_dmemReq = 1'b0;
    sample();
    check("lwbr_resolve", {25'd0, en_vec()}, {25'd0, EN_BR});
    tick();

    // Data miss: entry freeze + 3 DWAIT cycles, then dhit
    do_reset();
    mem_dmemReq = 1'b1; dhit = 1'b0;
    sample();
    check("dm_entry_en", {25'd0, en_vec()}, {25'd0, EN_NONE});
    check("dm_entry_state", {30'd0, state}, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      ihit = i[0]; branch_taken = i[1];
      sample();
      check("dm_wait_state", {30'd0, state}, 32'd1);
      check("dm_wait_en", {25'd0, en_vec()}, {25'd0, EN_NONE});
      tick();
    end
    ihit = 1'b1; branch_taken = 1'b0; dhit = 1'b1;
    sample();
    check("dm_hit_en", {25'd0, en_vec()}, {25'd0, EN_ALL});
    tick();
    clr();
    check("dm_after_state", {30'd0, state}, 32'd0);
    check("dm_stall_cnt", stall_cnt, PERF ? 32'd4 : 32'd0);

    // Reset out of DWAIT with stall_cnt at 5
    do_reset();
    mem_dmemReq = 1'b1; dhit = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("dw_state_pre", {30'd0, state}, 32'd1);
    check("dw_stall_pre", stall_cnt, PERF ? 32'd5 : 32'd0);
    RST = 1'b1;
    sample();
    check("dw_rst_en", {25'd0, en_vec()}, {25'd0, EN_NONE});
    tick();
    RST = 1'b0;
    clr();
    check("dw_rst_state", {30'd0, state}, 32'd0);
    check("dw_rst_stall", stall_cnt, 32'd0);

    // Halt during a load-use stall
    do_reset();
    ex_memRead = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; halt = 1'b1;
    sample();
    check("halt_cycle_en", {25'd0, en_vec()}, {25'd0, EN_STL});
    tick();
    check("halt_state", {30'd0, state}, 32'd2);
    check("halt_halted", {31'd0, halted}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      ihit = 1'($urandom_range(0, 1));
      dhit = 1'($urandom_range(0, 1));
      branch_taken = 1'($urandom_range(0, 1));
      mem_dmemReq = 1'($urandom_range(0, 1));
      ex_memRead = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1));
      sample();
      check("halted_en", {25'd0, en_vec()}, {25'd0, EN_NONE});
      tick();
      check("halted_state", {30'd0, state}, 32'd2);
    end
    check("halted_stall_cnt", stall_cnt, PERF ? 32'd1 : 32'd0);
    RST = 1'b1;
    clr();
    tick();
    RST = 1'b0;
    check("halt_rst_state", {30'd0, state}, 32'd0);
    check("halt_rst_halted", {31'd0, halted}, 32'd0);

    // Taken branch with fetch miss: redirect and count the flush
    do_reset();
    ihit = 1'b0; branch_taken = 1'b1;
    sample();
    check("brf_en", {25'd0, en_vec()}, {25'd0, EN_BR});
    tick();
    clr();
    check("brf_flush_cnt", flush_cnt, PERF ? 32'd1 : 32'd0);
    check("brf_stall_cnt", stall_cnt, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
